// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bus bundle: instruction memory, interrupt handler, hazard/branch inputs and IF/ID outputs.
// FETCH_PERF_CNT_EN adds the injCount/bubbleCount performance counter outputs.
interface fetch_pc_unit_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 16
) ();
  logic [PC_W-1:0]    instrMemAddr;
  logic [INSTR_W-1:0] instrMemData;
  logic               interruptRaisedInstruction;
  logic [INSTR_W-1:0] interruptInstruction;
  logic               interruptRaisedBubble;
  logic               interruptStall;
  logic               interruptRaisedToFetch;
  logic               hazardStall;
  logic               branchTaken;
  logic [PC_W-1:0]    branchTarget;
  logic [INSTR_W-1:0] instrOut;
  logic [PC_W-1:0]    pcOut;
  logic               validOut;
  logic [PC_W-1:0]    savedPc;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]        injCount;
  logic [15:0]        bubbleCount;

  modport slave (
    output instrMemAddr, instrOut, pcOut, validOut, savedPc, injCount, bubbleCount,
    input  instrMemData, interruptRaisedInstruction, interruptInstruction,
           interruptRaisedBubble, interruptStall, interruptRaisedToFetch,
           hazardStall, branchTaken, branchTarget
  );
  modport master (
    input  instrMemAddr, instrOut, pcOut, validOut, savedPc, injCount, bubbleCount,
    output instrMemData, interruptRaisedInstruction, interruptInstruction,
           interruptRaisedBubble, interruptStall, interruptRaisedToFetch,
           hazardStall, branchTaken, branchTarget
  );
`else
  modport slave (
    output instrMemAddr, instrOut, pcOut, validOut, savedPc,
    input  instrMemData, interruptRaisedInstruction, interruptInstruction,
           interruptRaisedBubble, interruptStall, interruptRaisedToFetch,
           hazardStall, branchTaken, branchTarget
  );
  modport master (
    input  instrMemAddr, instrOut, pcOut, validOut, savedPc,
    output instrMemData, interruptRaisedInstruction, interruptInstruction,
           interruptRaisedBubble, interruptStall, interruptRaisedToFetch,
           hazardStall, branchTaken, branchTarget
  );
`endif
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC owner: boots from the reset vector, vectors through the IVT, muxes injected words.
// Optional FETCH_PERF_CNT_EN adds saturating injected-word and bubble counters.
module fetch_pc_unit #(
  parameter int                PC_W           = 32,
  parameter int                INSTR_W        = 16,
  parameter logic [PC_W-1:0]   RESET_VEC_ADDR = '0,
  parameter logic [PC_W-1:0]   IVT_ADDR       = PC_W'(2),
  parameter logic [INSTR_W-1:0] NOP_WORD      = '0
) (
  input  logic           clk,
  input  logic           rst,
  fetch_pc_unit_if.slave bus
);
  localparam int HI_W = PC_W - 16;

  typedef enum logic [2:0] {BOOT_HI, BOOT_LO, RUN, VEC_HI, VEC_LO} state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_out_q, pc_out_d;
  logic               valid_q, valid_d;
  logic [PC_W-1:0]    saved_q, saved_d;
  logic               inj_active_q, inj_active_d;
  logic [PC_W-1:0]    mem_addr;

  // Address path kept separate from next-state logic so the memory read is not a comb loop.
  always_comb begin
    mem_addr = pc_q;
    case (state_q)
      BOOT_HI: mem_addr = RESET_VEC_ADDR;
      BOOT_LO: mem_addr = RESET_VEC_ADDR + PC_W'(1);
      VEC_HI:  mem_addr = IVT_ADDR;
      VEC_LO:  mem_addr = IVT_ADDR + PC_W'(1);
      default: mem_addr = pc_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    valid_d      = valid_q;
    saved_d      = saved_q;
    inj_active_d = inj_active_q;
    case (state_q)
      BOOT_HI, VEC_HI: begin
        pc_d    = {HI_W'(bus.instrMemData), pc_q[15:0]};
        instr_d = NOP_WORD;
        valid_d = 1'b0;
        state_d = (state_q == BOOT_HI) ? BOOT_LO : VEC_LO;
      end
      BOOT_LO, VEC_LO: begin
        pc_d    = {pc_q[PC_W-1:16], 16'(bus.instrMemData)};
        instr_d = NOP_WORD;
        valid_d = 1'b0;
        state_d = RUN;
      end
      RUN: begin
        if (bus.interruptRaisedToFetch) begin
          state_d      = VEC_HI;
          instr_d      = NOP_WORD;
          valid_d      = 1'b0;
          inj_active_d = 1'b0;
        end else if (bus.interruptRaisedInstruction) begin
          // Injection beats a same-cycle branch; the handler resolves jumps beforehand.
          instr_d = bus.interruptInstruction;
          valid_d = !bus.interruptRaisedBubble;
          if (!bus.interruptRaisedBubble && !inj_active_q) begin
            saved_d      = pc_q;
            inj_active_d = 1'b1;
          end
        end else if (bus.hazardStall) begin
          // Everything holds via defaults.
        end else if (bus.interruptStall) begin
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end else if (bus.branchTaken) begin
          pc_d    = bus.branchTarget;
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end else begin
          instr_d  = bus.instrMemData;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          pc_d     = pc_q + PC_W'(1);
        end
      end
      default: state_d = BOOT_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= BOOT_HI;
      pc_q         <= '0;
      instr_q      <= NOP_WORD;
      pc_out_q     <= '0;
      valid_q      <= 1'b0;
      saved_q      <= '0;
      inj_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      pc_out_q     <= pc_out_d;
      valid_q      <= valid_d;
      saved_q      <= saved_d;
      inj_active_q <= inj_active_d;
    end
  end

  assign bus.instrMemAddr = mem_addr;
  assign bus.instrOut     = instr_q;
  assign bus.pcOut        = pc_out_q;
  assign bus.validOut     = valid_q;
  assign bus.savedPc      = saved_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] inj_cnt_q, inj_cnt_d;
  logic [15:0] bub_cnt_q, bub_cnt_d;
  logic        inj_evt, bub_evt;

  always_comb begin
    inj_evt   = (state_q == RUN) && !bus.interruptRaisedToFetch &&
                bus.interruptRaisedInstruction && !bus.interruptRaisedBubble;
    bub_evt   = (state_q == RUN) && !valid_d;
    inj_cnt_d = inj_cnt_q;
    bub_cnt_d = bub_cnt_q;
    if (inj_evt && inj_cnt_q != 16'hFFFF) inj_cnt_d = inj_cnt_q + 16'd1;
    if (bub_evt && bub_cnt_q != 16'hFFFF) bub_cnt_d = bub_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      inj_cnt_q <= '0;
      bub_cnt_q <= '0;
    end else begin
      inj_cnt_q <= inj_cnt_d;
      bub_cnt_q <= bub_cnt_d;
    end
  end

  assign bus.injCount    = inj_cnt_q;
  assign bus.bubbleCount = bub_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: boot, hazard freeze, interrupt injection/vectoring, branch vs injection, wrap, reset in vector load.
module tb_fetch_pc_unit;
  logic clk = 1'b0;
  logic rst;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  logic [15:0] mem [0:1023];

  fetch_pc_unit_if #(.PC_W(32), .INSTR_W(16)) bus ();
  fetch_pc_unit dut (.clk(clk), .rst(rst), .bus(bus));

  assign bus.instrMemData = mem[bus.instrMemAddr[9:0]];

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.interruptRaisedInstruction = 1'b0;
    bus.interruptInstruction       = 16'h0;
    bus.interruptRaisedBubble      = 1'b0;
    bus.interruptStall             = 1'b0;
    bus.interruptRaisedToFetch     = 1'b0;
    bus.hazardStall                = 1'b0;
    bus.branchTaken                = 1'b0;
    bus.branchTarget               = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    step();
    step();
    total_cnt++;
    if ({bus.instrOut, bus.pcOut, bus.validOut} !== {16'h0, 32'h0, 1'b0})
      $display("FAIL reset_outs: got %h/%h/%b want 0000/00000000/0", bus.instrOut, bus.pcOut, bus.validOut);
    else pass_cnt++;
    total_cnt++;
    if (bus.savedPc !== 32'h0) $display("FAIL reset_saved: got %h want 00000000", bus.savedPc);
    else pass_cnt++;
    total_cnt++;
    if (bus.instrMemAddr !== 32'h0) $display("FAIL reset_addr: got %h want 00000000", bus.instrMemAddr);
    else pass_cnt++;
`ifdef FETCH_PERF_CNT_EN
    total_cnt++;
    if ({bus.injCount, bus.bubbleCount} !== 32'h0)
      $display("FAIL reset_cnt: got %h/%h want 0/0", bus.injCount, bus.bubbleCount);
    else pass_cnt++;
`endif
  endtask

  task automatic test_boot();
    rst = 1'b1;
    step();
    total_cnt++;
    if ({bus.instrMemAddr, bus.validOut} !== {32'h1, 1'b0})
      $display("FAIL boot_lo_addr: got %h/%b want 00000001/0", bus.instrMemAddr, bus.validOut);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({bus.instrMemAddr, bus.validOut} !== {32'h20, 1'b0})
      $display("FAIL boot_pc: got %h/%b want 00000020/0", bus.instrMemAddr, bus.validOut);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({bus.instrOut, bus.pcOut, bus.validOut} !== {16'hABCD, 32'h20, 1'b1})
      $display("FAIL boot_first: got %h/%h/%b want abcd/00000020/1", bus.instrOut, bus.pcOut, bus.validOut);
    else pass_cnt++;
  endtask

  task automatic test_hazard();
    bus.branchTaken = 1'b1; bus.branchTarget = 32'h2F;
    step();
    total_cnt++;
    if ({bus.validOut, bus.instrOut, bus.instrMemAddr} !== {1'b0, 16'h0, 32'h2F})
      $display("FAIL hz_branch: got %b/%h/%h want 0/0000/0000002f", bus.validOut, bus.instrOut, bus.instrMemAddr);
    else pass_cnt++;
    bus.branchTaken = 1'b0;
    step();
    bus.hazardStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++;
      if ({bus.instrOut, bus.pcOut, bus.validOut, bus.instrMemAddr} !== {16'hA02F, 32'h2F, 1'b1, 32'h30})
        $display("FAIL hz_hold%0d: got %h/%h/%b/%h want a02f/0000002f/1/00000030",
                 i, bus.instrOut, bus.pcOut, bus.validOut, bus.instrMemAddr);
      else pass_cnt++;
    end
    bus.hazardStall = 1'b0;
    step();
    total_cnt++;
    if ({bus.instrOut, bus.pcOut, bus.validOut} !== {16'hA030, 32'h30, 1'b1})
      $display("FAIL hz_resume: got %h/%h/%b want a030/00000030/1", bus.instrOut, bus.pcOut, bus.validOut);
    else pass_cnt++;
  endtask

  task automatic test_interrupt();
    logic [15:0] words [4] = '{16'h1111, 16'h2222, 16'hF480, 16'h0042};
    logic        bub   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] sav   [4] = '{32'h0, 32'h0, 32'h24, 32'h24};
    bus.branchTaken = 1'b1; bus.branchTarget = 32'h24;
    step();
    bus.branchTaken = 1'b0;
    bus.interruptStall = 1'b1;
    bus.interruptRaisedInstruction = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.interruptInstruction  = words[i];
      bus.interruptRaisedBubble = bub[i];
      step();
      total_cnt++;
      if ({bus.instrOut, bus.validOut, bus.savedPc, bus.instrMemAddr} !== {words[i], !bub[i], sav[i], 32'h24})
        $display("FAIL inj%0d: got %h/%b/%h/%h want %h/%b/%h/00000024", i, bus.instrOut, bus.validOut,
                 bus.savedPc, bus.instrMemAddr, words[i], !bub[i], sav[i]);
      else pass_cnt++;
    end
    bus.interruptRaisedInstruction = 1'b0;
    bus.interruptRaisedBubble = 1'b0;
    step();
    total_cnt++;
    if ({bus.instrOut, bus.validOut, bus.instrMemAddr} !== {16'h0, 1'b0, 32'h24})
      $display("FAIL int_stall: got %h/%b/%h want 0000/0/00000024", bus.instrOut, bus.validOut, bus.instrMemAddr);
    else pass_cnt++;
    bus.interruptRaisedToFetch = 1'b1;
    step();
    total_cnt++;
    if ({bus.instrOut, bus.validOut, bus.instrMemAddr} !== {16'h0, 1'b0, 32'h2})
      $display("FAIL vec_hi: got %h/%b/%h want 0000/0/00000002", bus.instrOut, bus.validOut, bus.instrMemAddr);
    else pass_cnt++;
    bus.interruptRaisedToFetch = 1'b0;
    bus.interruptStall = 1'b0;
    step();
    total_cnt++;
    if (bus.instrMemAddr !== 32'h3) $display("FAIL vec_lo: got %h want 00000003", bus.instrMemAddr);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({bus.validOut, bus.instrMemAddr} !== {1'b0, 32'h100})
      $display("FAIL vec_pc: got %b/%h want 0/00000100", bus.validOut, bus.instrMemAddr);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({bus.instrOut, bus.pcOut, bus.validOut} !== {16'hA100, 32'h100, 1'b1})
      $display("FAIL vec_fetch: got %h/%h/%b want a100/00000100/1", bus.instrOut, bus.pcOut, bus.validOut);
    else pass_cnt++;
`ifdef FETCH_PERF_CNT_EN
    total_cnt++;
    if (bus.injCount !== 16'd2) $display("FAIL inj_count: got %0d want 2", bus.injCount);
    else pass_cnt++;
`endif
  endtask

  task automatic test_branch_vs_inj();
    bus.branchTaken = 1'b1; bus.branchTarget = 32'h50;
    bus.interruptRaisedInstruction = 1'b1; bus.interruptInstruction = 16'hBEEF;
    step();
    total_cnt++;
    if ({bus.instrOut, bus.validOut, bus.instrMemAddr} !== {16'hBEEF, 1'b1, 32'h101})
      $display("FAIL br_inj: got %h/%b/%h want beef/1/00000101", bus.instrOut, bus.validOut, bus.instrMemAddr);
    else pass_cnt++;
    bus.interruptRaisedInstruction = 1'b0;
    step();
    total_cnt++;
    if ({bus.instrOut, bus.validOut, bus.instrMemAddr} !== {16'h0, 1'b0, 32'h50})
      $display("FAIL br_alone: got %h/%b/%h want 0000/0/00000050", bus.instrOut, bus.validOut, bus.instrMemAddr);
    else pass_cnt++;
    bus.branchTaken = 1'b0;
  endtask

  task automatic test_wrap();
    mem[0] = 16'h1234;
    bus.branchTaken = 1'b1; bus.branchTarget = 32'hFFFF_FFFF;
    step();
    bus.branchTaken = 1'b0;
    step();
    total_cnt++;
    if ({bus.instrOut, bus.pcOut, bus.validOut, bus.instrMemAddr} !== {16'hA3FF, 32'hFFFF_FFFF, 1'b1, 32'h0})
      $display("FAIL wrap_top: got %h/%h/%b/%h want a3ff/ffffffff/1/00000000",
               bus.instrOut, bus.pcOut, bus.validOut, bus.instrMemAddr);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({bus.instrOut, bus.pcOut, bus.validOut, bus.instrMemAddr} !== {16'h1234, 32'h0, 1'b1, 32'h1})
      $display("FAIL wrap_zero: got %h/%h/%b/%h want 1234/00000000/1/00000001",
               bus.instrOut, bus.pcOut, bus.validOut, bus.instrMemAddr);
    else pass_cnt++;
    mem[0] = 16'h0000;
  endtask

  task automatic test_reset_in_vec();
    bus.interruptRaisedToFetch = 1'b1;
    step();
    bus.interruptRaisedToFetch = 1'b0;
    step();
    total_cnt++;
    if (bus.instrMemAddr !== 32'h3) $display("FAIL rv_vec_lo: got %h want 00000003", bus.instrMemAddr);
    else pass_cnt++;
    rst = 1'b0;
    step();
    total_cnt++;
    if ({bus.instrMemAddr, bus.instrOut, bus.pcOut, bus.validOut, bus.savedPc} !== {32'h0, 16'h0, 32'h0, 1'b0, 32'h0})
      $display("FAIL rv_reset: got %h/%h/%h/%b/%h want 00000000/0000/00000000/0/00000000",
               bus.instrMemAddr, bus.instrOut, bus.pcOut, bus.validOut, bus.savedPc);
    else pass_cnt++;
`ifdef FETCH_PERF_CNT_EN
    total_cnt++;
    if ({bus.injCount, bus.bubbleCount} !== 32'h0)
      $display("FAIL rv_cnt: got %h/%h want 0/0", bus.injCount, bus.bubbleCount);
    else pass_cnt++;
`endif
    rst = 1'b1;
    step();
    step();
    total_cnt++;
    if ({bus.instrMemAddr, bus.validOut} !== {32'h20, 1'b0})
      $display("FAIL rv_reboot: got %h/%b want 00000020/0", bus.instrMemAddr, bus.validOut);
    else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'hA000 | 16'(i);
    mem[0]    = 16'h0000;
    mem[1]    = 16'h0020;
    mem[2]    = 16'h0000;
    mem[3]    = 16'h0100;
    mem[16'h20] = 16'hABCD;
    test_reset();
    test_boot();
    test_hazard();
    test_interrupt();
    test_branch_vs_inj();
    test_wrap();
    test_reset_in_vec();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
